pwm_breath: RTL and testbench

PWM_BREATH -- requirements
Module: pwm_breath

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_tick_div.sv | 29 ++
 rtl/pwm_breath.sv | 156 +++++++++++++++
 tb/tb_pwm_breath.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the breathing-PWM sweep and the downstream pwm stage.
package pwm_pkg;

  localparam int unsigned PWM_N_DEF  = 32;
  localparam int unsigned PWM_HW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIXED,
    ST_UP,
    ST_HOLD_HI,
    ST_DOWN,
    ST_HOLD_LO
  } pwm_state_e;

endpackage

// File: rtl/pwm_tick_div.sv
// Update-tick generator: counts 0..max(div,1)-1 and pulses tick on the last count.
module pwm_tick_div #(
  parameter int unsigned N = pwm_pkg::PWM_N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [N-1:0] div,
  output logic         tick
);

  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] last;

  // A divider of 0 behaves as 1, i.e. a tick on every clock.
  assign last = (div == '0) ? '0 : div - N'(1);
  assign tick = !clr && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q + N'(1);
    if (clr || cnt_q >= last) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_breath.sv
// Breathing duty sweep: ramps duty between latched limits with dwell at each end.
module pwm_breath
  import pwm_pkg::*;
#(
  parameter int unsigned N  = PWM_N_DEF,
  parameter int unsigned HW = PWM_HW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  duty_min,
  input  logic [N-1:0]  duty_max,
  input  logic [N-1:0]  step,
  input  logic [N-1:0]  tick_div,
  input  logic [HW-1:0] hold,
  output logic [N-1:0]  duty,
  output logic          dir,
  output logic          busy,
  output logic          cycle_done
);

  pwm_state_e    state_q, state_d;
  logic [N-1:0]  duty_q, duty_d;
  logic          dir_q, dir_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [HW-1:0] hcnt_q, hcnt_d;

  logic [N-1:0]  min_q, max_q, step_q, div_q;
  logic [HW-1:0] hold_q;
  logic          lat_q;
  logic          latch;

  logic          tick;
  logic [N:0]    sum, diff;
  logic [HW-1:0] hcnt_inc;
  logic          hold_done;

  // Counter runs only while sweeping with en high; any IDLE cycle restarts it.
  pwm_tick_div #(.N(N)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  ((state_q == ST_IDLE) || !en),
    .div  (div_q),
    .tick (tick)
  );

  assign sum       = {1'b0, duty_q} + {1'b0, step_q};
  assign diff      = {1'b0, duty_q} - {1'b0, step_q};
  assign hcnt_inc  = hcnt_q + HW'(1);
  assign hold_done = (hold_q == '0) || (hcnt_inc == hold_q);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
    latch   = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      duty_d  = lat_q ? min_q : duty_min;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          latch   = 1'b1;
          duty_d  = duty_min;
          hcnt_d  = '0;
          state_d = (duty_min >= duty_max || step == '0) ? ST_FIXED : ST_UP;
        end
        ST_FIXED: ;
        ST_UP: if (tick) begin
          if (sum >= {1'b0, max_q}) begin
            duty_d  = max_q;
            state_d = ST_HOLD_HI;
            hcnt_d  = '0;
          end else begin
            duty_d  = sum[N-1:0];
          end
        end
        ST_HOLD_HI: if (tick) begin
          if (hold_done) begin
            state_d = ST_DOWN;
            hcnt_d  = '0;
          end else begin
            hcnt_d  = hcnt_inc;
          end
        end
        // Borrow out of the N+1-bit difference means the step undershot zero.
        ST_DOWN: if (tick) begin
          if (diff[N] || diff[N-1:0] <= min_q) begin
            duty_d  = min_q;
            state_d = ST_HOLD_LO;
            hcnt_d  = '0;
            done_d  = 1'b1;
          end else begin
            duty_d  = diff[N-1:0];
          end
        end
        ST_HOLD_LO: if (tick) begin
          if (hold_done) begin
            state_d = ST_UP;
            hcnt_d  = '0;
          end else begin
            hcnt_d  = hcnt_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    dir_d  = (state_d == ST_UP) || (state_d == ST_HOLD_HI);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hcnt_q  <= hcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q  <= '0;
      max_q  <= '0;
      step_q <= '0;
      div_q  <= '0;
      hold_q <= '0;
      lat_q  <= 1'b0;
    end else if (latch) begin
      min_q  <= duty_min;
      max_q  <= duty_max;
      step_q <= step;
      div_q  <= tick_div;
      hold_q <= hold;
      lat_q  <= 1'b1;
    end
  end

  assign duty       = duty_q;
  assign dir        = dir_q;
  assign busy       = busy_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_pwm_breath.sv
// Bench for pwm_breath (N=8, HW=4): per-tick sweep sequence model plus directed vectors.
module tb_pwm_breath;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] dmin, dmax, step, tdiv;
  logic [3:0] hold;
  logic [7:0] duty;
  logic       dir, busy, cycle_done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pwm_breath #(.N(8), .HW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .duty_min  (dmin),
    .duty_max  (dmax),
    .step      (step),
    .tick_div  (tdiv),
    .hold      (hold),
    .duty      (duty),
    .dir       (dir),
    .busy      (busy),
    .cycle_done(cycle_done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: one sweep period as the list of (duty, dir, done) seen after each tick.
  int sd[$], sdir[$], sdone[$];
  int e_duty = 0, e_dir = 0, e_busy = 0, e_done = 0;
  bit m_run = 0, m_fixed = 0, m_lat = 0;
  int m_min = 0, m_td = 1, m_clk = 0, m_ticks = 0;

  function automatic void add(input int d, input int r, input int c);
    sd.push_back(d); sdir.push_back(r); sdone.push_back(c);
  endfunction

  function automatic void build(input int mn, input int mx, input int st, input int hd);
    int v;
    int h;
    sd.delete(); sdir.delete(); sdone.delete();
    h = (hd == 0) ? 1 : hd;
    v = mn + st;
    while (v < mx) begin add(v, 1, 0); v += st; end
    add(mx, 1, 0);
    for (int i = 1; i <= h; i++) add(mx, (i == h) ? 0 : 1, 0);
    v = mx - st;
    while (v > mn) begin add(v, 0, 0); v -= st; end
    add(mn, 0, 1);
    for (int i = 1; i <= h; i++) add(mn, (i == h) ? 1 : 0, 0);
  endfunction

  task automatic model_step();
    int idx;
    if (!rst_n) begin
      e_duty = 0; e_dir = 0; e_busy = 0; e_done = 0;
      m_run = 0; m_fixed = 0; m_lat = 0; m_min = 0;
      return;
    end
    e_done = 0;
    if (!en) begin
      e_duty = m_lat ? m_min : int'(dmin);
      e_dir = 0; e_busy = 0; m_run = 0;
    end else if (!m_run) begin
      m_run = 1; m_lat = 1; m_min = int'(dmin);
      m_td = (tdiv == 0) ? 1 : int'(tdiv);
      m_fixed = (dmin >= dmax) || (step == 0);
      e_duty = int'(dmin); e_busy = 1; e_dir = m_fixed ? 0 : 1;
      m_clk = 0; m_ticks = 0;
      if (!m_fixed) build(int'(dmin), int'(dmax), int'(step), int'(hold));
    end else begin
      m_clk++;
      if (!m_fixed && (m_clk % m_td) == 0) begin
        idx = m_ticks % sd.size();
        m_ticks++;
        e_duty = sd[idx]; e_dir = sdir[idx]; e_done = sdone[idx];
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("m_duty", int'(duty), e_duty);
    chk("m_dir", int'(dir), e_dir);
    chk("m_busy", int'(busy), e_busy);
    chk("m_done", int'(cycle_done), e_done);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int kcur;

  task automatic cfg(input int mn, input int mx, input int st, input int td, input int hd);
    dmin = 8'(mn); dmax = 8'(mx); step = 8'(st); tdiv = 8'(td); hold = 4'(hd);
  endtask

  // Raise en; returns on the IDLE exit edge.
  task automatic start();
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk);
    kcur = 0;
  endtask

  task automatic step_to(input int k);
    repeat (k - kcur) @(posedge clk);
    @(negedge clk);
    kcur = k;
  endtask

  task automatic stop(input int exp_duty, input string nm);
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_duty"}, int'(duty), exp_duty);
    chk({nm, "_busy"}, int'(busy), 0);
    repeat (3) @(posedge clk);
  endtask

  int tA[19] = '{0, 10, 10, 20, 20, 30, 30, 35, 35, 35, 35, 25, 25, 15, 15, 5, 5, 0, 0};

  initial begin
    rst_n = 1'b0; en = 1'b0;
    cfg(0, 0, 0, 0, 0);
    #2;
    chk("rst_duty", int'(duty), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_done", int'(cycle_done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic sweep with hold of one tick at each end.
    cfg(0, 35, 10, 2, 1);
    start();
    for (int k = 1; k <= 19; k++) begin
      step_to(k);
      chk("A_duty", int'(duty), tA[k-1]);
      if (k == 9)  chk("A_dir_hold", int'(dir), 1);
      if (k == 10) chk("A_dir_down", int'(dir), 0);
      if (k == 18) chk("A_done_pulse", int'(cycle_done), 1);
      if (k == 19) chk("A_done_clear", int'(cycle_done), 0);
    end
    repeat (20) @(posedge clk);
    stop(0, "A_stop");

    // Limits next to the top of the range: no wrap either way.
    cfg(250, 255, 10, 1, 2);
    start();
    step_to(1); chk("B_up_sat", int'(duty), 255);
    step_to(3); chk("B_dir_down", int'(dir), 0);
    step_to(4); chk("B_dn_sat", int'(duty), 250);
    chk("B_done", int'(cycle_done), 1);
    repeat (20) @(posedge clk);
    stop(250, "B_stop");

    // Degenerate configs park in FIXED.
    cfg(40, 40, 5, 1, 0);
    start();
    step_to(1);  chk("C_duty", int'(duty), 40); chk("C_busy", int'(busy), 1);
    step_to(15); chk("C_duty_late", int'(duty), 40); chk("C_done", int'(cycle_done), 0);
    stop(40, "C_stop");
    cfg(10, 50, 0, 1, 0);
    start();
    step_to(5); chk("C0_duty", int'(duty), 10); chk("C0_dir", int'(dir), 0);
    stop(10, "C0_stop");

    // Divider 0 and hold 0: tick every clock, one-clock holds.
    cfg(0, 3, 2, 0, 0);
    start();
    step_to(1); chk("D_duty1", int'(duty), 2);
    step_to(2); chk("D_duty2", int'(duty), 3); chk("D_dir2", int'(dir), 1);
    step_to(3); chk("D_duty3", int'(duty), 3); chk("D_dir3", int'(dir), 0);
    step_to(4); chk("D_duty4", int'(duty), 1);
    step_to(5); chk("D_duty5", int'(duty), 0); chk("D_done5", int'(cycle_done), 1);
    step_to(6); chk("D_dir6", int'(dir), 1); chk("D_done6", int'(cycle_done), 0);
    step_to(7); chk("D_duty7", int'(duty), 2);
    repeat (10) @(posedge clk);
    stop(0, "D_stop");

    // en falls on the same clock as an UP tick.
    cfg(5, 200, 7, 3, 1);
    start();
    step_to(3); chk("E_duty3", int'(duty), 12);
    step_to(5); chk("E_duty5", int'(duty), 12);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("E_duty_idle", int'(duty), 5);
    chk("E_busy_idle", int'(busy), 0);
    chk("E_dir_idle", int'(dir), 0);
    repeat (3) @(posedge clk);

    // Asynchronous reset mid-DOWN, then a fresh sweep from new limits.
    cfg(0, 100, 20, 1, 1);
    start();
    step_to(7); chk("F_duty7", int'(duty), 80); chk("F_dir7", int'(dir), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("F_rst_duty", int'(duty), 0);
    chk("F_rst_busy", int'(busy), 0);
    chk("F_rst_dir", int'(dir), 0);
    chk("F_rst_done", int'(cycle_done), 0);
    dmin = 8'd30; dmax = 8'd90;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("F_new_duty", int'(duty), 30);
    chk("F_new_busy", int'(busy), 1);
    repeat (30) @(posedge clk);
    stop(30, "F_stop");

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
